fft_bin_gain_sched: RTL

Per-bin gain scheduler for the receiver's FFT output path. It accepts a stream of complex FFT bins, tracks the bin index within each frame, and looks up that bin's 8-bit signed gain from a runtime-writable table. It drives the shared real-by-complex `multiplier` with the bin sample and gain, and registers the scaled result onto a valid/ready output stream. It also enforces frame alignment and reports framing errors.

---
 rtl/rx_pkg.sv | 19 +
 rtl/fft_bin_gain_sched_if.sv | 39 +++
 rtl/multiplier.sv | 23 ++
 rtl/fft_bin_gain_sched.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared receiver definitions: sample width, the gain-table reset value and
// the framing state encoding used by the FFT bin gain scheduler.
// ---------------------------------------------------------------------------
package rx_pkg;

    localparam int SAMPLE_W = 8;

    // Every gain-table entry comes out of reset as unity so that an
    // unconfigured table passes samples through unchanged.
    localparam logic signed [SAMPLE_W-1:0] GAIN_UNITY = 8'sd1;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_t;

endpackage

// File: rtl/fft_bin_gain_sched_if.sv
// ---------------------------------------------------------------------------
// fft_bin_gain_sched_if
// Input and output sample streams of the FFT bin gain scheduler.
//   in_valid/in_ready            : input handshake
//   in_re/in_im/in_last          : signed complex bin and end-of-frame flag
//   out_valid/out_ready          : output handshake
//   out_re/out_im/out_bin/out_last : scaled bin, its index, end-of-frame flag
// master : sample producer / sink side (drives inputs, consumes outputs)
// slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface fft_bin_gain_sched_if #(
    parameter int BIN_W = 6
);
    import rx_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic signed [SAMPLE_W-1:0]  in_re;
    logic signed [SAMPLE_W-1:0]  in_im;
    logic                        in_last;

    logic                        out_valid;
    logic                        out_ready;
    logic signed [SAMPLE_W-1:0]  out_re;
    logic signed [SAMPLE_W-1:0]  out_im;
    logic        [BIN_W-1:0]     out_bin;
    logic                        out_last;

    modport master (
        output in_valid, in_re, in_im, in_last, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_bin, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, in_last, out_ready,
        output in_ready, out_valid, out_re, out_im, out_bin, out_last
    );

endinterface

// File: rtl/multiplier.sv
// ---------------------------------------------------------------------------
// multiplier
// Combinational real-by-complex multiplier: scales both parts of a complex
// sample by one real signed coefficient, full-precision products.
//   i_re, i_im : signed complex sample (DATA_W)
//   i_gain     : signed real coefficient (COEF_W)
//   o_re, o_im : signed products (DATA_W+COEF_W)
// ---------------------------------------------------------------------------
module multiplier #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
) (
    input  logic signed [DATA_W-1:0]        i_re,
    input  logic signed [DATA_W-1:0]        i_im,
    input  logic signed [COEF_W-1:0]        i_gain,
    output logic signed [DATA_W+COEF_W-1:0] o_re,
    output logic signed [DATA_W+COEF_W-1:0] o_im
);

    assign o_re = i_re * i_gain;
    assign o_im = i_im * i_gain;

endmodule

// File: rtl/fft_bin_gain_sched.sv
// ---------------------------------------------------------------------------
// fft_bin_gain_sched
// Per-bin gain scheduler for the FFT output path. Counts bins within a frame,
// scales each bin by its entry in a runtime-writable gain table, registers
// the wrapped 8-bit result onto a valid/ready stream and polices framing.
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : input and output sample streams
//   cfg_we/addr/gain    : gain table write port
//   frame_err           : one-cycle pulse per framing error
//   err_count           : saturating framing error count
// ---------------------------------------------------------------------------
module fft_bin_gain_sched
    import rx_pkg::*;
#(
    parameter int N_BINS = 64,
    parameter int BIN_W  = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    fft_bin_gain_sched_if.slave        bus,
    input  logic                       cfg_we,
    input  logic        [BIN_W-1:0]    cfg_addr,
    input  logic signed [SAMPLE_W-1:0] cfg_gain,
    output logic                       frame_err,
    output logic        [7:0]          err_count
);

    localparam int PROD_W = 2 * SAMPLE_W;
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(N_BINS - 1);

    // Keep the low byte of the product; overflow wraps by design.
    function automatic logic signed [SAMPLE_W-1:0] wrap_s8(input logic signed [PROD_W-1:0] p);
        return p[SAMPLE_W-1:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic        [BIN_W-1:0]     r_bin;
    logic        [BIN_W-1:0]     w_bin_nxt;
    logic signed [SAMPLE_W-1:0]  r_gain [N_BINS];
    logic signed [SAMPLE_W-1:0]  w_gain;

    logic                        r_out_valid;
    logic signed [SAMPLE_W-1:0]  r_out_re_p1;
    logic signed [SAMPLE_W-1:0]  r_out_im_p1;
    logic        [BIN_W-1:0]     r_out_bin_p1;
    logic                        r_out_last_p1;
    logic                        r_frame_err;
    logic        [7:0]           r_err_count;

    logic                        w_in_ready;
    logic                        w_accept;
    logic                        w_emit;
    logic                        w_err;
    logic signed [PROD_W-1:0]    w_prod_re;
    logic signed [PROD_W-1:0]    w_prod_im;

    // DROP never produces output, so it may swallow inputs even while a
    // previous sample is still waiting downstream.
    assign w_in_ready = (r_state == DROP) || !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Asynchronous read of the current bin: a same-cycle write lands at the
    // edge, so the accepted sample sees the old gain.
    assign w_gain = r_gain[r_bin];

    multiplier #(
        .DATA_W (SAMPLE_W),
        .COEF_W (SAMPLE_W)
    ) u_mult (
        .i_re   (bus.in_re),
        .i_im   (bus.in_im),
        .i_gain (w_gain),
        .o_re   (w_prod_re),
        .o_im   (w_prod_im)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_emit      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            RUN: begin
                if (w_accept) begin
                    w_emit = 1'b1;
                    if (bus.in_last) begin
                        w_bin_nxt = '0;
                        w_err     = (r_bin != BIN_LAST);
                    end else if (r_bin == BIN_LAST) begin
                        // Frame overran without a last marker: resync on the next one.
                        w_err       = 1'b1;
                        w_state_nxt = DROP;
                        w_bin_nxt   = '0;
                    end else begin
                        w_bin_nxt = r_bin + BIN_W'(1);
                    end
                end
            end
            DROP: begin
                if (w_accept && bus.in_last) begin
                    w_state_nxt = RUN;
                    w_bin_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_bin_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_bin   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_BINS; i++) begin
                r_gain[i] <= GAIN_UNITY;
            end
        end else if (cfg_we) begin
            r_gain[cfg_addr] <= cfg_gain;
        end
    end

    // ---- stage p1: output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_re_p1   <= '0;
            r_out_im_p1   <= '0;
            r_out_bin_p1  <= '0;
            r_out_last_p1 <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_count   <= '0;
        end else begin
            if (w_emit) begin
                r_out_valid   <= 1'b1;
                r_out_re_p1   <= wrap_s8(w_prod_re);
                r_out_im_p1   <= wrap_s8(w_prod_im);
                r_out_bin_p1  <= r_bin;
                r_out_last_p1 <= bus.in_last;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_frame_err <= w_err;
            if (w_err) begin
                r_err_count <= sat_inc8(r_err_count);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_re    = r_out_re_p1;
    assign bus.out_im    = r_out_im_p1;
    assign bus.out_bin   = r_out_bin_p1;
    assign bus.out_last  = r_out_last_p1;
    assign frame_err     = r_frame_err;
    assign err_count     = r_err_count;

endmodule
